attach_user_hls_deadlock_report: RTL and testbench

- Downstream consumer of the per-instance deadlock monitor's `block` / `axis_block_info` outputs.
- Debounces the raw block indication over a programmable number of consecutive cycles and declares a sticky deadlock.
- On detection it captures the blocked-channel info, raises a one-cycle interrupt, counts the event and emits one report word over a valid/ready handshake for the debug/status path.

---
 rtl/attach_user_hls_deadlock_report.sv | 143 ++++++++++++++
 tb/tb_attach_user_hls_deadlock_report.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attach_user_hls_deadlock_report.sv
// attach_user_hls_deadlock_report
//   Consumes the deadlock monitor's raw block flag and per-channel info.
//   Debounces block over a programmable run length, latches a sticky
//   deadlock, pulses irq, counts events and emits one report word over a
//   valid/ready handshake.
// Ports:
//   clock, reset_n            clock and asynchronous active-low reset
//   block, axis_block_info    raw monitor outputs (2 bits per channel)
//   threshold                 consecutive block cycles needed (0 acts as 1)
//   clear                     acknowledge / clear the sticky deadlock
//   deadlock, irq             sticky status and one-cycle detection pulse
//   captured_info, blocked_mask  info latched at detection, per-channel OR
//   event_count, stall_cycles saturating detection count and run length
//   report_valid/ready/data   report word handshake
//   report_overflow           sticky; detection while a report was pending
module attach_user_hls_deadlock_report #(
  parameter int NUM_AXIS = 2,
  parameter int INFO_W   = 2 * NUM_AXIS,
  parameter int THRESH_W = 16,
  parameter int CNT_W    = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      block,
  input  logic [INFO_W-1:0]         axis_block_info,
  input  logic [THRESH_W-1:0]       threshold,
  input  logic                      clear,
  output logic                      deadlock,
  output logic                      irq,
  output logic [INFO_W-1:0]         captured_info,
  output logic [NUM_AXIS-1:0]       blocked_mask,
  output logic [CNT_W-1:0]          event_count,
  output logic [THRESH_W-1:0]       stall_cycles,
  output logic                      report_valid,
  input  logic                      report_ready,
  output logic [CNT_W+INFO_W-1:0]   report_data,
  output logic                      report_overflow
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DETECTED
  } state_t;

  state_t state;

  logic [THRESH_W-1:0] thr;
  logic [THRESH_W:0]   stall_inc;
  logic [THRESH_W-1:0] stall_sat;
  logic [CNT_W-1:0]    cnt_inc;
  logic                hit;
  logic                detect;
  logic                accept;

  always_comb begin
    thr       = (threshold == '0) ? THRESH_W'(1) : threshold;
    stall_inc = {1'b0, stall_cycles} + 1'b1;
    stall_sat = (&stall_cycles) ? stall_cycles : stall_inc[THRESH_W-1:0];
    cnt_inc   = (&event_count) ? event_count : event_count + 1'b1;
    accept    = report_valid && report_ready;
    hit       = 1'b0;
    case (state)
      IDLE:    hit = block && (thr == THRESH_W'(1));
      // >= keeps a run from slipping past a threshold lowered mid-count
      COUNT:   hit = block && (stall_inc >= {1'b0, thr});
      default: hit = 1'b0;
    endcase
    // clear beats a detection landing in the same cycle
    detect = hit && !clear;
  end

  always_comb begin
    blocked_mask = '0;
    for (int unsigned i = 0; i < NUM_AXIS; i++)
      blocked_mask[i] = |captured_info[2*i +: 2];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      deadlock        <= 1'b0;
      irq             <= 1'b0;
      captured_info   <= '0;
      event_count     <= '0;
      stall_cycles    <= '0;
      report_valid    <= 1'b0;
      report_data     <= '0;
      report_overflow <= 1'b0;
    end else begin
      irq <= detect;

      if (clear) begin
        state           <= IDLE;
        stall_cycles    <= '0;
        deadlock        <= 1'b0;
        captured_info   <= '0;
        report_overflow <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (block) begin
              stall_cycles <= THRESH_W'(1);
              state        <= hit ? DETECTED : COUNT;
            end else begin
              stall_cycles <= '0;
            end
          end
          COUNT: begin
            if (!block) begin
              state        <= IDLE;
              stall_cycles <= '0;
            end else begin
              stall_cycles <= stall_inc[THRESH_W-1:0];
              if (hit) state <= DETECTED;
            end
          end
          DETECTED: begin
            if (block) stall_cycles <= stall_sat;
          end
          default: state <= IDLE;
        endcase
      end

      if (detect) begin
        deadlock      <= 1'b1;
        captured_info <= axis_block_info;
        event_count   <= cnt_inc;
      end

      // a same-cycle accept frees the slot, so the new word loads cleanly
      if (detect && (!report_valid || accept)) begin
        report_valid <= 1'b1;
        report_data  <= {cnt_inc, axis_block_info};
      end else if (detect) begin
        report_overflow <= 1'b1;
      end else if (accept) begin
        report_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_attach_user_hls_deadlock_report.sv
module tb_attach_user_hls_deadlock_report;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        block = 1'b0;
  logic [3:0]  axis_block_info = '0;
  logic [15:0] threshold = '0;
  logic        clear = 1'b0;
  logic        deadlock, irq;
  logic [3:0]  captured_info;
  logic [1:0]  blocked_mask;
  logic [7:0]  event_count;
  logic [15:0] stall_cycles;
  logic        report_valid;
  logic        report_ready = 1'b0;
  logic [11:0] report_data;
  logic        report_overflow;

  int tests = 0;
  int fails = 0;

  attach_user_hls_deadlock_report #(
    .NUM_AXIS(2), .INFO_W(4), .THRESH_W(16), .CNT_W(8)
  ) dut (
    .clock(clock), .reset_n(reset_n), .block(block),
    .axis_block_info(axis_block_info), .threshold(threshold), .clear(clear),
    .deadlock(deadlock), .irq(irq), .captured_info(captured_info),
    .blocked_mask(blocked_mask), .event_count(event_count),
    .stall_cycles(stall_cycles), .report_valid(report_valid),
    .report_ready(report_ready), .report_data(report_data),
    .report_overflow(report_overflow)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    tests++;
    if ({deadlock, irq, captured_info, blocked_mask, event_count, stall_cycles,
         report_valid, report_data, report_overflow} !== '0) begin
      fails++;
      $display("FAIL reset_state: got dl=%b irq=%b cap=%h cnt=%0d stall=%0d rv=%b rd=%h ovf=%b, want all 0",
               deadlock, irq, captured_info, event_count, stall_cycles,
               report_valid, report_data, report_overflow);
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_no_detect();
    int peak = 0;
    int irqs = 0;
    threshold = 16'd4;
    block = 1'b1;
    axis_block_info = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      if (irq) irqs++;
      if (int'(stall_cycles) > peak) peak = int'(stall_cycles);
    end
    tests++;
    if (deadlock !== 1'b0) begin
      fails++; $display("FAIL no_detect_deadlock: got %b want 0", deadlock);
    end
    block = 1'b0;
    step();
    if (irq) irqs++;
    tests++;
    if (peak != 3) begin
      fails++; $display("FAIL no_detect_peak: got %0d want 3", peak);
    end
    tests++;
    if (stall_cycles !== 16'd0) begin
      fails++; $display("FAIL no_detect_stall_return: got %0d want 0", stall_cycles);
    end
    tests++;
    if (irqs != 0 || deadlock !== 1'b0) begin
      fails++; $display("FAIL no_detect_irq: got irqs=%0d dl=%b want 0/0", irqs, deadlock);
    end
  endtask

  task automatic test_detect();
    threshold = 16'd4;
    block = 1'b1;
    axis_block_info = 4'b0010;
    report_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (irq !== 1'b0 || deadlock !== 1'b0) begin
        fails++; $display("FAIL detect_early_%0d: got irq=%b dl=%b want 0/0", i, irq, deadlock);
      end
    end
    step();
    tests++;
    if (deadlock !== 1'b1 || irq !== 1'b1 || stall_cycles !== 16'd4) begin
      fails++; $display("FAIL detect_edge: got dl=%b irq=%b stall=%0d want 1/1/4", deadlock, irq, stall_cycles);
    end
    tests++;
    if (captured_info !== 4'b0010 || blocked_mask !== 2'b01 || event_count !== 8'd1) begin
      fails++; $display("FAIL detect_capture: got cap=%b mask=%b cnt=%0d want 0010/01/1",
                        captured_info, blocked_mask, event_count);
    end
    tests++;
    if (report_valid !== 1'b1 || report_data !== {8'd1, 4'b0010}) begin
      fails++; $display("FAIL detect_report: got rv=%b rd=%h want 1/012", report_valid, report_data);
    end
    step();
    tests++;
    if (irq !== 1'b0 || deadlock !== 1'b1 || stall_cycles !== 16'd5) begin
      fails++; $display("FAIL detect_hold: got irq=%b dl=%b stall=%0d want 0/1/5", irq, deadlock, stall_cycles);
    end
  endtask

  task automatic test_overflow();
    block = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    tests++;
    if (deadlock !== 1'b0 || stall_cycles !== 16'd0 || event_count !== 8'd1 || report_valid !== 1'b1) begin
      fails++; $display("FAIL overflow_clear: got dl=%b stall=%0d cnt=%0d rv=%b want 0/0/1/1",
                        deadlock, stall_cycles, event_count, report_valid);
    end
    threshold = 16'd1;
    block = 1'b1;
    axis_block_info = 4'b0100;
    step();
    block = 1'b0;
    tests++;
    if (report_data !== {8'd1, 4'b0010} || report_overflow !== 1'b1 || event_count !== 8'd2 || irq !== 1'b1) begin
      fails++; $display("FAIL overflow_redetect: got rd=%h ovf=%b cnt=%0d irq=%b want 012/1/2/1",
                        report_data, report_overflow, event_count, irq);
    end
    report_ready = 1'b1;
    step();
    tests++;
    if (report_valid !== 1'b0) begin
      fails++; $display("FAIL overflow_drain: got rv=%b want 0", report_valid);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    tests++;
    if (report_overflow !== 1'b0 || deadlock !== 1'b0) begin
      fails++; $display("FAIL overflow_cleared: got ovf=%b dl=%b want 0/0", report_overflow, deadlock);
    end
  endtask

  task automatic test_thresh_zero_one();
    logic [15:0] thr_vals [2];
    thr_vals[0] = 16'd0;
    thr_vals[1] = 16'd1;
    for (int k = 0; k < 2; k++) begin
      threshold = thr_vals[k];
      block = 1'b1;
      axis_block_info = 4'b0100;
      step();
      block = 1'b0;
      tests++;
      if (deadlock !== 1'b1 || irq !== 1'b1 || blocked_mask !== 2'b10 || stall_cycles !== 16'd1 ||
          event_count !== 8'(3 + k) || report_data !== {8'(3 + k), 4'b0100}) begin
        fails++; $display("FAIL thresh_%0d: got dl=%b irq=%b mask=%b stall=%0d cnt=%0d rd=%h want 1/1/10/1/%0d",
                          thr_vals[k], deadlock, irq, blocked_mask, stall_cycles, event_count, report_data, 3 + k);
      end
      clear = 1'b1;
      step();
      clear = 1'b0;
    end
  endtask

  task automatic test_clear_wins();
    threshold = 16'd1;
    block = 1'b1;
    clear = 1'b1;
    step();
    tests++;
    if (irq !== 1'b0 || deadlock !== 1'b0 || event_count !== 8'd4 || stall_cycles !== 16'd0) begin
      fails++; $display("FAIL clear_wins_idle: got irq=%b dl=%b cnt=%0d stall=%0d want 0/0/4/0",
                        irq, deadlock, event_count, stall_cycles);
    end
    clear = 1'b0;
    threshold = 16'd3;
    step();
    step();
    clear = 1'b1;
    step();
    tests++;
    if (irq !== 1'b0 || deadlock !== 1'b0 || event_count !== 8'd4 || stall_cycles !== 16'd0) begin
      fails++; $display("FAIL clear_wins_count: got irq=%b dl=%b cnt=%0d stall=%0d want 0/0/4/0",
                        irq, deadlock, event_count, stall_cycles);
    end
    clear = 1'b0;
    block = 1'b0;
    step();
  endtask

  task automatic test_saturate();
    int exp_cnt = 4;
    threshold = 16'd1;
    report_ready = 1'b1;
    axis_block_info = 4'b1111;
    while (exp_cnt < 255) begin
      block = 1'b1; clear = 1'b0;
      step();
      exp_cnt++;
      block = 1'b0; clear = 1'b1;
      step();
    end
    clear = 1'b0;
    tests++;
    if (event_count !== 8'd255) begin
      fails++; $display("FAIL saturate_reach: got %0d want 255", event_count);
    end
    block = 1'b1;
    step();
    block = 1'b0;
    tests++;
    if (event_count !== 8'd255 || irq !== 1'b1 || report_data !== {8'd255, 4'b1111} || blocked_mask !== 2'b11) begin
      fails++; $display("FAIL saturate_hold: got cnt=%0d irq=%b rd=%h mask=%b want 255/1/ff f/11",
                        event_count, irq, report_data, blocked_mask);
    end
    clear = 1'b1;
    step();
    block = 1'b1;
    step();
    tests++;
    if (irq !== 1'b0 || event_count !== 8'd255 || deadlock !== 1'b0) begin
      fails++; $display("FAIL saturate_clear_wins: got irq=%b cnt=%0d dl=%b want 0/255/0", irq, event_count, deadlock);
    end
    block = 1'b0;
    clear = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    threshold = 16'd1;
    report_ready = 1'b0;
    axis_block_info = 4'b0011;
    block = 1'b1;
    step();
    tests++;
    if (deadlock !== 1'b1 || report_valid !== 1'b1) begin
      fails++; $display("FAIL areset_setup: got dl=%b rv=%b want 1/1", deadlock, report_valid);
    end
    #3;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({deadlock, irq, captured_info, blocked_mask, event_count, stall_cycles,
         report_valid, report_data, report_overflow} !== '0) begin
      fails++; $display("FAIL areset_immediate: got dl=%b irq=%b cnt=%0d stall=%0d rv=%b rd=%h want all 0",
                        deadlock, irq, event_count, stall_cycles, report_valid, report_data);
    end
    block = 1'b0;
    step();
    reset_n = 1'b1;
    report_ready = 1'b1;
    step();
    step();
    tests++;
    if (report_valid !== 1'b0 || deadlock !== 1'b0 || stall_cycles !== 16'd0) begin
      fails++; $display("FAIL areset_after: got rv=%b dl=%b stall=%0d want 0/0/0", report_valid, deadlock, stall_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_no_detect();
    test_detect();
    test_overflow();
    test_thresh_zero_one();
    test_clear_wins();
    test_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
